// File: rtl/sprite_slot_pkg.sv
// Shared definitions for the sprite slot loader: slot register map and loader states.
package sprite_slot_pkg;

    localparam int         SLOT_REG_BIT = 13;
    localparam logic [1:0] REG_BYPASS   = 2'b00;
    localparam logic [1:0] REG_X0       = 2'b01;
    localparam logic [1:0] REG_Y0       = 2'b10;
    localparam logic [1:0] REG_CTRL     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIDE,
        ST_COPY,
        ST_REG_X,
        ST_REG_Y,
        ST_REG_C,
        ST_REG_B,
        ST_DONE
    } ldr_state_e;

    function automatic logic [13:0] reg_addr(input logic [1:0] sel);
        logic [13:0] a;
        a               = '0;
        a[SLOT_REG_BIT] = 1'b1;
        a[1:0]          = sel;
        return a;
    endfunction

endpackage

// File: rtl/sprite_slot_loader.sv
// Copies a sprite bitmap from an external sync ROM into the sprite slot RAM,
// hiding the sprite during the copy and then programming x0/y0/ctrl/bypass.
module sprite_slot_loader
    import sprite_slot_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int PIX_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [10:0]           cfg_x0,
    input  logic [10:0]           cfg_y0,
    input  logic [4:0]            cfg_ctrl,
    input  logic                  cfg_bypass,
    output logic                  busy,
    output logic                  done,
    output logic                  src_rd,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [PIX_W-1:0]      src_data,
    output logic                  cs,
    output logic                  write,
    output logic [13:0]           addr,
    output logic [31:0]           wr_data
);

    localparam int             CW   = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    ldr_state_e            state_q, state_d;
    logic [CW-1:0]         k_q, k_d;
    logic [10:0]           x0_q, x0_d, y0_q, y0_d;
    logic [4:0]            ctrl_q, ctrl_d;
    logic                  byp_q, byp_d;
    logic                  busy_q, busy_d, done_q, done_d, cs_q, cs_d;
    logic                  src_rd_q, src_rd_d, pix_q, pix_d;
    logic [ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic [13:0]           addr_q, addr_d;
    logic [31:0]           wdat_q, wdat_d;
    logic [CW-1:0]         k_nx, k_nx2;

    assign k_nx  = k_q + CW'(1);
    assign k_nx2 = k_q + CW'(2);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        ctrl_d     = ctrl_q;
        byp_d      = byp_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        cs_d       = 1'b0;
        src_rd_d   = 1'b0;
        pix_d      = 1'b0;
        src_addr_d = '0;
        addr_d     = '0;
        wdat_d     = '0;
        // Outputs are computed for the state being entered, so they show up registered.
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_HIDE;
                    x0_d     = cfg_x0;
                    y0_d     = cfg_y0;
                    ctrl_d   = cfg_ctrl;
                    byp_d    = cfg_bypass;
                    busy_d   = 1'b1;
                    cs_d     = 1'b1;
                    addr_d   = reg_addr(REG_BYPASS);
                    wdat_d   = 32'd1;
                    src_rd_d = 1'b1;
                end
            end
            ST_HIDE: begin
                state_d    = ST_COPY;
                k_d        = '0;
                busy_d     = 1'b1;
                cs_d       = 1'b1;
                pix_d      = 1'b1;
                src_rd_d   = (LAST != '0);
                src_addr_d = ADDR_WIDTH'(1);
            end
            ST_COPY: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
                if (k_q == LAST) begin
                    state_d = ST_REG_X;
                    addr_d  = reg_addr(REG_X0);
                    wdat_d  = 32'(x0_q);
                end else begin
                    k_d        = k_nx;
                    pix_d      = 1'b1;
                    addr_d     = 14'(k_nx[ADDR_WIDTH-1:0]);
                    src_rd_d   = (k_nx != LAST);
                    src_addr_d = k_nx2[ADDR_WIDTH-1:0];
                end
            end
            ST_REG_X: begin
                state_d = ST_REG_Y;
                busy_d  = 1'b1;
                cs_d    = 1'b1;
                addr_d  = reg_addr(REG_Y0);
                wdat_d  = 32'(y0_q);
            end
            ST_REG_Y: begin
                state_d = ST_REG_C;
                busy_d  = 1'b1;
                cs_d    = 1'b1;
                addr_d  = reg_addr(REG_CTRL);
                wdat_d  = 32'(ctrl_q);
            end
            ST_REG_C: begin
                state_d = ST_REG_B;
                busy_d  = 1'b1;
                cs_d    = 1'b1;
                addr_d  = reg_addr(REG_BYPASS);
                wdat_d  = 32'(byp_q);
            end
            ST_REG_B: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            ctrl_q     <= '0;
            byp_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_q       <= 1'b0;
            src_rd_q   <= 1'b0;
            pix_q      <= 1'b0;
            src_addr_q <= '0;
            addr_q     <= '0;
            wdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            ctrl_q     <= ctrl_d;
            byp_q      <= byp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_q       <= cs_d;
            src_rd_q   <= src_rd_d;
            pix_q      <= pix_d;
            src_addr_q <= src_addr_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cs       = cs_q;
    assign write    = cs_q;
    assign src_rd   = src_rd_q;
    assign src_addr = src_addr_q;
    assign addr     = addr_q;
    // Pixel data comes straight from the ROM's output register; a second flop here would cost a cycle per load.
    assign wr_data  = pix_q ? 32'(src_data) : wdat_q;

endmodule

// File: doc/sprite_slot_loader.md
# sprite_slot_loader

Bus initiator for the video slot interface of a sprite core. On a start pulse it hides the sprite with the bypass register and copies one full sprite bitmap, 2 bits per pixel, from a synchronous source ROM into the sprite RAM at one pixel per clock. It then writes the x0, y0, ctrl and bypass registers and pulses done. It sits between the processor-side control logic and the sprite core slot, so a sprite can be reloaded without CPU bus traffic.

## Interface
Parameters:
- ADDR_WIDTH, 10: sprite RAM address width; 2**ADDR_WIDTH pixels are copied per load.
- PIX_W, 2: pixel width in bits.

Ports (clock and reset first):
- clk  in  1: the only clock.
- reset  in  1: synchronous, active-high.
- start  in  1: load request, sampled only in IDLE.
- cfg_x0  in  11: sprite x origin.
- cfg_y0  in  11: sprite y origin.
- cfg_ctrl  in  5: value written to the ctrl register.
- cfg_bypass  in  1: final bypass value.
- busy  out  1: high from HIDE through REG_B.
- done  out  1: one-cycle pulse when the load completes.
- src_rd  out  1: source ROM read strobe.
- src_addr  out  ADDR_WIDTH: source ROM pixel address.
- src_data  in  PIX_W: ROM data, valid exactly 1 cycle after src_rd.
- cs  out  1: slot chip select.
- write  out  1: slot write strobe; always equal to cs.
- addr  out  14: slot address.
- wr_data  out  32: slot write data.

## Operation
- Slot map:
  - addr[13]=0 selects the RAM, with the pixel index in addr[ADDR_WIDTH-1:0].
  - addr[13]=1 selects the registers by addr[1:0]: 00 bypass, 01 x0, 10 y0, 11 ctrl.
  - The register addresses used are 0x2000 through 0x2003.
- States: IDLE, HIDE, COPY, REG_X, REG_Y, REG_C, REG_B, DONE.
- IDLE:
  - cs, write, src_rd and busy are 0.
  - If start=1, latch all cfg_* inputs and go to HIDE.
  - cfg_* changes after the start cycle have no effect.
- HIDE (1 cycle):
  - Write bypass=1: addr=0x2000, wr_data=1.
  - Issue src_rd=1 with src_addr=0.
- COPY (2**ADDR_WIDTH cycles, index k counts 0 up to the last pixel):
  - Write addr={0, k} with wr_data={0, src_data}, using the data returned for the read issued in the previous cycle.
  - Issue src_rd with src_addr=k+1 while k is below the last index.
  - In the last cycle, src_rd=0.
- REG_X, REG_Y, REG_C, REG_B (1 cycle each):
  - Write the latched x0, y0, ctrl and bypass to 0x2001, 0x2002, 0x2003 and 0x2000 respectively.
- DONE (1 cycle):
  - done=1, busy=0, cs=0, then go to IDLE.
  - A start in the DONE cycle is ignored.
- Width rules:
  - wr_data bits above the field width are 0: [31:11] for x0/y0, [31:5] for ctrl, [31:1] for bypass, [31:PIX_W] for pixels.
  - addr bits [12:ADDR_WIDTH] are 0 for RAM writes.
  - The index counter is ADDR_WIDTH+1 bits wide, so it terminates without wrap.
- start while busy: ignored, with no queueing.
- Reset mid-load:
  - Next state is IDLE with all outputs 0.
  - Writes already issued are not undone, so the sprite may remain bypassed.

## Timing
- start sampled high at edge 0 places HIDE in cycle 1.
- COPY runs in cycles 2 through 2**ADDR_WIDTH+1.
- For ADDR_WIDTH=10:
  - REG_X is cycle 1026, REG_Y 1027, REG_C 1028, REG_B 1029.
  - DONE is cycle 1030.
- Exactly 2**ADDR_WIDTH+5 slot writes per load (1029 for ADDR_WIDTH=10), one per cycle, with no idle bubbles.
- src_rd has one-cycle read-to-use latency; the ROM is never read more than once per address per load.
- All outputs are registered.
- Reset values: busy=0, done=0, cs=0, write=0, src_rd=0, addr=0, wr_data=0, src_addr=0.

## Structure
- Shared package sprite_slot_pkg holds:
  - localparams SLOT_REG_BIT=13, REG_BYPASS=2'b00, REG_X0=2'b01, REG_Y0=2'b10, REG_CTRL=2'b11;
  - the loader state enum typedef.
- Single module with no sub-module.
- The source ROM is external, so the same loader can feed different sprite bitmaps.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, no slot write.
- start with cfg_x0=100, cfg_y0=200, cfg_ctrl=5'h04, cfg_bypass=0, and a ROM holding pixel k = k mod 4 -> write sequence:
  - (0x2000, 1);
  - then (k, k mod 4) for k=0..1023;
  - then (0x2001, 100), (0x2002, 200), (0x2003, 4), (0x2000, 0);
  - done in cycle 1030, with 1029 writes total.
- start pulses in cycles 5 and 500 and in the DONE cycle after the first start -> only one load; change cfg_x0 in cycle 3 -> x0 write still carries the latched value.
- reset asserted in cycle 300 of COPY -> next cycle all outputs 0 and state IDLE; a new start then performs a full 1029-write load.
- Back-to-back: start in the cycle after done -> second load begins HIDE one cycle later, identical write sequence.
- cfg_x0=11'h7FF, cfg_ctrl=5'h1F -> wr_data exactly 0x000007FF and 0x0000001F, with upper bits 0.
